// File: rtl/combo_decoder.sv
// Button combo decoder: rising-edge press detection, fixed-length press sequence
// collection under an inter-press timeout, skill code output and post-skill cooldown.
module combo_decoder #(
    parameter int NUM_BTN  = 2,
    parameter int SEQ_LEN  = 3,
    parameter int TIMEOUT  = 16,
    parameter int COOLDOWN = 2,
    localparam int CODE_W  = (NUM_BTN == 2) ? 1 : 2,
    localparam int SKILL_W = SEQ_LEN * CODE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic [SKILL_W-1:0] skill,
    output logic               skill_valid,
    output logic               teleport,
    output logic               heavy,
    output logic               abort,
    output logic [1:0]         state,
    output logic [2:0]         count
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int SEQ_W = SKILL_W - CODE_W;

    localparam logic [1:0]        ST_IDLE     = 2'b00;
    localparam logic [1:0]        ST_COLLECT  = 2'b01;
    localparam logic [1:0]        ST_COOLDOWN = 2'b10;
    localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_ZERO    = TMR_W'(0);
    localparam logic [CD_W-1:0]   CD_LAST     = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [CD_W-1:0]   CD_ONE      = CD_W'(1);
    localparam logic [CD_W-1:0]   CD_ZERO     = CD_W'(0);
    localparam logic [2:0]        CNT_LAST    = 3'(SEQ_LEN - 1);
    localparam logic [CODE_W-1:0] CODE_HEAVY  = CODE_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] btn_q;
    logic [SEQ_W-1:0]   seq_q,   seq_d;
    logic [SKILL_W-1:0] skill_q, skill_d;
    logic               valid_q, valid_d;
    logic               tele_q,  tele_d;
    logic               heavy_q, heavy_d;
    logic               abort_q, abort_d;
    logic [1:0]         state_q, state_d;
    logic [2:0]         count_q, count_d;
    logic [TMR_W-1:0]   tmr_q,   tmr_d;
    logic [CD_W-1:0]    cd_q,    cd_d;

    logic [NUM_BTN-1:0] press_s;
    logic [2:0]         n_press_s;
    logic [CODE_W-1:0]  code_s;
    logic [SKILL_W-1:0] shifted_s;
    logic               tele_s;
    logic               heavy_s;

    // Press decode and the skill word this press would complete.
    always_comb begin
        press_s   = btn & ~btn_q;
        n_press_s = 3'd0;
        code_s    = {CODE_W{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            n_press_s = n_press_s + {2'b00, press_s[i]};
            code_s    = press_s[i] ? CODE_W'(i) : code_s;
        end
        // Older slots shift towards the MSBs, so the first press lands on top.
        shifted_s = {seq_q, code_s};
        tele_s    = 1'b1;
        for (int s = 0; s < SEQ_LEN; s++) begin
            tele_s = tele_s & (shifted_s[SKILL_W-1-s*CODE_W -: CODE_W] == code_s);
        end
        heavy_s = (code_s == CODE_HEAVY) & ~tele_s;
    end

    // Sequence FSM next-state logic.
    always_comb begin
        seq_d   = seq_q;
        skill_d = skill_q;
        valid_d = 1'b0;
        tele_d  = tele_q;
        heavy_d = heavy_q;
        abort_d = 1'b0;
        state_d = state_q;
        count_d = count_q;
        tmr_d   = tmr_q;
        cd_d    = cd_q;
        case (state_q)
            ST_IDLE: begin
                if (n_press_s == 3'd1) begin
                    seq_d   = shifted_s[SEQ_W-1:0];
                    count_d = 3'd1;
                    tmr_d   = TMR_ZERO;
                    state_d = ST_COLLECT;
                end else if (n_press_s > 3'd1) begin
                    abort_d = 1'b1;
                end else begin
                    tmr_d = TMR_ZERO;
                end
            end
            ST_COLLECT: begin
                if (n_press_s == 3'd1) begin
                    seq_d = shifted_s[SEQ_W-1:0];
                    tmr_d = TMR_ZERO;
                    if (count_q == CNT_LAST) begin
                        skill_d = shifted_s;
                        tele_d  = tele_s;
                        heavy_d = heavy_s;
                        valid_d = 1'b1;
                        count_d = 3'd0;
                        cd_d    = CD_ZERO;
                        state_d = (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end else if (n_press_s > 3'd1) begin
                    abort_d = 1'b1;
                    count_d = 3'd0;
                    tmr_d   = TMR_ZERO;
                    state_d = ST_IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    abort_d = 1'b1;
                    count_d = 3'd0;
                    tmr_d   = TMR_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_COOLDOWN: begin
                if (cd_q == CD_LAST) begin
                    cd_d    = CD_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cd_d = cd_q + CD_ONE;
                end
            end
            default: begin
                count_d = 3'd0;
                tmr_d   = TMR_ZERO;
                cd_d    = CD_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; btn_q resets high so held buttons need a release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q   <= {NUM_BTN{1'b1}};
            seq_q   <= {SEQ_W{1'b0}};
            skill_q <= {SKILL_W{1'b0}};
            valid_q <= 1'b0;
            tele_q  <= 1'b0;
            heavy_q <= 1'b0;
            abort_q <= 1'b0;
            state_q <= ST_IDLE;
            count_q <= 3'd0;
            tmr_q   <= TMR_ZERO;
            cd_q    <= CD_ZERO;
        end else begin
            btn_q   <= btn;
            seq_q   <= seq_d;
            skill_q <= skill_d;
            valid_q <= valid_d;
            tele_q  <= tele_d;
            heavy_q <= heavy_d;
            abort_q <= abort_d;
            state_q <= state_d;
            count_q <= count_d;
            tmr_q   <= tmr_d;
            cd_q    <= cd_d;
        end
    end

    assign skill       = skill_q;
    assign skill_valid = valid_q;
    assign teleport    = tele_q;
    assign heavy       = heavy_q;
    assign abort       = abort_q;
    assign state       = state_q;
    assign count       = count_q;

endmodule

// File: tb/tb_combo_decoder.sv
// Bench for combo_decoder: a 2-button/3-press instance and a 4-button/4-press,
// no-cooldown instance, both checked against a press-queue reference model.
module tb_combo_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn2 = 2'b00;
    logic [3:0] btn4 = 4'b0000;

    logic [2:0] skill2;
    logic       valid2, tele2, heavy2, abort2;
    logic [1:0] state2;
    logic [2:0] count2;
    logic [7:0] skill4;
    logic       valid4, tele4, heavy4, abort4;
    logic [1:0] state4;
    logic [2:0] count4;

    combo_decoder dut2 (
        .clk(clk), .reset(rst_n), .btn(btn2), .skill(skill2), .skill_valid(valid2),
        .teleport(tele2), .heavy(heavy2), .abort(abort2), .state(state2), .count(count2)
    );

    combo_decoder #(.NUM_BTN(4), .SEQ_LEN(4), .TIMEOUT(16), .COOLDOWN(0)) dut4 (
        .clk(clk), .reset(rst_n), .btn(btn4), .skill(skill4), .skill_valid(valid4),
        .teleport(tele4), .heavy(heavy4), .abort(abort4), .state(state4), .count(count4)
    );

    always #5 clk = ~clk;

    logic [11:0] obs2;
    logic [16:0] obs4;
    assign obs2 = {skill2, valid2, tele2, heavy2, abort2, state2, count2};
    assign obs4 = {skill4, valid4, tele4, heavy4, abort4, state4, count4};

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 = 2-button instance, index 1 = 4-button instance.
    int NB[2]  = '{2, 4};
    int SL[2]  = '{3, 4};
    int CDN[2] = '{2, 0};
    int prev_m[2], n_m[2], idle_m[2], cd_m[2], mode_m[2], skill_m[2];
    int slot_m[2][4];
    bit valid_m[2], tele_m[2], heavy_m[2], abort_m[2];
    logic [3:0] stim[$];

    task automatic mreset(input int id);
        prev_m[id] = (1 << NB[id]) - 1;
        n_m[id] = 0; idle_m[id] = 0; cd_m[id] = 0; mode_m[id] = 0; skill_m[id] = 0;
        valid_m[id] = 1'b0; tele_m[id] = 1'b0; heavy_m[id] = 1'b0; abort_m[id] = 1'b0;
    endtask

    task automatic mstep(input int id, input int b);
        int press, np, code;
        press = b & ~prev_m[id];
        prev_m[id] = b;
        np = 0; code = 0;
        for (int i = 0; i < NB[id]; i++) begin
            if (((press >> i) & 1) == 1) begin np++; code = i; end
        end
        valid_m[id] = 1'b0;
        abort_m[id] = 1'b0;
        if (mode_m[id] == 2) begin
            cd_m[id]--;
            if (cd_m[id] == 0) mode_m[id] = 0;
        end else if (np > 1) begin
            abort_m[id] = 1'b1; n_m[id] = 0; mode_m[id] = 0;
        end else if (np == 1) begin
            slot_m[id][n_m[id]] = code;
            n_m[id]++; idle_m[id] = 0; mode_m[id] = 1;
            if (n_m[id] == SL[id]) begin
                skill_m[id] = 0; tele_m[id] = 1'b1;
                for (int s = 0; s < SL[id]; s++) begin
                    skill_m[id] = skill_m[id] * NB[id] + slot_m[id][s];
                    if (slot_m[id][s] != slot_m[id][0]) tele_m[id] = 1'b0;
                end
                heavy_m[id] = (code == NB[id] - 1) && !tele_m[id];
                valid_m[id] = 1'b1;
                n_m[id] = 0;
                mode_m[id] = (CDN[id] > 0) ? 2 : 0;
                cd_m[id] = CDN[id];
            end
        end else if (mode_m[id] == 1) begin
            idle_m[id]++;
            if (idle_m[id] == 16) begin
                abort_m[id] = 1'b1; n_m[id] = 0; mode_m[id] = 0;
            end
        end
    endtask

    function automatic logic [11:0] exp2();
        return {3'(skill_m[0]), valid_m[0], tele_m[0], heavy_m[0], abort_m[0], 2'(mode_m[0]), 3'(n_m[0])};
    endfunction

    function automatic logic [16:0] exp4();
        return {8'(skill_m[1]), valid_m[1], tele_m[1], heavy_m[1], abort_m[1], 2'(mode_m[1]), 3'(n_m[1])};
    endfunction

    task automatic tick(input logic [1:0] b2, input logic [3:0] b4);
        btn2 = b2;
        btn4 = b4;
        @(posedge clk);
        if (rst_n) begin
            mstep(0, int'(b2));
            mstep(1, int'(b4));
        end
        #1;
    endtask

    task automatic push_press(input int c);
        logic [3:0] v;
        v = 4'(1 << c);
        stim.push_back(v); stim.push_back(v);
        stim.push_back(4'd0); stim.push_back(4'd0);
    endtask

    task automatic settle();
        repeat (20) tick(2'b00, 4'd0);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        if (obs2 !== 12'h000) begin errors++; $display("FAIL reset2: got %h want 000", obs2); end
        checks++;
        if (obs4 !== 17'h00000) begin errors++; $display("FAIL reset4: got %h want 00000", obs4); end
        checks++;
        @(negedge clk) rst_n = 1'b1;
        tick(2'b00, 4'd0);
        if ({obs2, obs4} !== {exp2(), exp4()}) begin
            errors++; $display("FAIL reset_release: got %h/%h want %h/%h", obs2, obs4, exp2(), exp4());
        end
        checks++;
    endtask

    task automatic test_teleport();
        int pulses = 0, cool = 0;
        stim.delete();
        repeat (3) push_press(0);
        repeat (4) stim.push_back(4'd0);
        foreach (stim[k]) begin
            tick(stim[k][1:0], 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL teleport cyc%0d: got %h want %h", k, obs2, exp2()); end
            checks++;
            pulses += int'(valid2);
            if (state2 == 2'b10) cool++;
        end
        if (pulses != 1 || cool != 2) begin errors++; $display("FAIL teleport_pulses: got %0d/%0d want 1/2", pulses, cool); end
        checks++;
        if ({skill2, tele2, heavy2, state2} !== {3'b000, 1'b1, 1'b0, 2'b00}) begin
            errors++; $display("FAIL teleport_out: got %b %b %b %b want 000 1 0 00", skill2, tele2, heavy2, state2);
        end
        checks++;
    endtask

    task automatic test_heavy();
        stim.delete();
        push_press(0); push_press(0); push_press(1);
        foreach (stim[k]) begin
            tick(stim[k][1:0], 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL heavy001 cyc%0d: got %h want %h", k, obs2, exp2()); end
            checks++;
        end
        if ({skill2, tele2, heavy2} !== {3'b001, 1'b0, 1'b1}) begin
            errors++; $display("FAIL heavy001_out: got %b %b %b want 001 0 1", skill2, tele2, heavy2);
        end
        checks++;
        stim.delete();
        repeat (3) push_press(1);
        foreach (stim[k]) begin
            tick(stim[k][1:0], 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL tele111 cyc%0d: got %h want %h", k, obs2, exp2()); end
            checks++;
        end
        if ({skill2, tele2, heavy2} !== {3'b111, 1'b1, 1'b0}) begin
            errors++; $display("FAIL tele111_out: got %b %b %b want 111 1 0", skill2, tele2, heavy2);
        end
        checks++;
    endtask

    task automatic test_timeout();
        int first = -1, sawv = 0;
        stim.delete();
        push_press(0); push_press(1); push_press(0);
        foreach (stim[k]) begin
            tick(stim[k][1:0], 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL timeout_setup cyc%0d: got %h want %h", k, obs2, exp2()); end
            checks++;
        end
        tick(2'b01, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            tick((i == 1) ? 2'b01 : 2'b00, 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL timeout cyc%0d: got %h want %h", i, obs2, exp2()); end
            checks++;
            if (abort2 === 1'b1 && first < 0) first = i;
            sawv += int'(valid2);
        end
        if (first != 16 || sawv != 0) begin errors++; $display("FAIL timeout_when: got %0d/%0d want 16/0", first, sawv); end
        checks++;
        if ({skill2, state2, count2} !== {3'b010, 2'b00, 3'd0}) begin
            errors++; $display("FAIL timeout_out: got %b %b %0d want 010 00 0", skill2, state2, count2);
        end
        checks++;
    endtask

    task automatic test_press_at_timeout();
        int aborts = 0;
        for (int i = 0; i <= 16; i++) begin
            tick((i < 2) ? 2'b01 : ((i == 16) ? 2'b10 : 2'b00), 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL press_at_to cyc%0d: got %h want %h", i, obs2, exp2()); end
            checks++;
            aborts += int'(abort2);
        end
        if (aborts != 0 || count2 !== 3'd2) begin errors++; $display("FAIL press_at_to_out: got %0d/%0d want 0/2", aborts, count2); end
        checks++;
        settle();
    endtask

    task automatic test_clash();
        logic [1:0] seq[5] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b11};
        int aborts = 0;
        foreach (seq[k]) begin
            tick(seq[k], 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL clash cyc%0d: got %h want %h", k, obs2, exp2()); end
            checks++;
            aborts += int'(abort2);
        end
        if (aborts != 2 || count2 !== 3'd0) begin errors++; $display("FAIL clash_out: got %0d/%0d want 2/0", aborts, count2); end
        checks++;
        settle();
    endtask

    task automatic test_cooldown();
        int aborts = 0;
        stim.delete();
        push_press(1); push_press(0);
        stim.push_back(4'd2); stim.push_back(4'd0); stim.push_back(4'd1);
        stim.push_back(4'd1); stim.push_back(4'd0); stim.push_back(4'd0);
        foreach (stim[k]) begin
            tick(stim[k][1:0], 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL cooldown cyc%0d: got %h want %h", k, obs2, exp2()); end
            checks++;
            aborts += int'(abort2);
        end
        if (aborts != 0 || count2 !== 3'd0 || skill2 !== 3'b101) begin
            errors++; $display("FAIL cooldown_out: got %0d/%0d/%b want 0/0/101", aborts, count2, skill2);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        stim.delete();
        push_press(0); push_press(0);
        foreach (stim[k]) tick(stim[k][1:0], 4'd0);
        if (count2 !== 3'd2) begin errors++; $display("FAIL mid_count: got %0d want 2", count2); end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (obs2 !== 12'h000) begin errors++; $display("FAIL mid_reset: got %h want 000", obs2); end
        checks++;
        mreset(0); mreset(1);
        btn2 = 2'b11;
        @(negedge clk); @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(2'b11, 4'd0);
            if (obs2 !== exp2()) begin errors++; $display("FAIL held cyc%0d: got %h want %h", i, obs2, exp2()); end
            checks++;
        end
        if (count2 !== 3'd0 || abort2 !== 1'b0) begin errors++; $display("FAIL held_out: got %0d/%b want 0/0", count2, abort2); end
        checks++;
        tick(2'b00, 4'd0);
    endtask

    task automatic test_four();
        int order[2][4] = '{'{3, 2, 1, 0}, '{1, 1, 1, 3}};
        logic [7:0] want_skill[2] = '{8'b11100100, 8'b01010111};
        logic       want_heavy[2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            stim.delete();
            for (int p = 0; p < 4; p++) push_press(order[t][p]);
            foreach (stim[k]) begin
                tick(2'b00, stim[k]);
                if (obs4 !== exp4()) begin errors++; $display("FAIL four%0d cyc%0d: got %h want %h", t, k, obs4, exp4()); end
                checks++;
            end
            if (skill4 !== want_skill[t] || heavy4 !== want_heavy[t] || tele4 !== 1'b0) begin
                errors++; $display("FAIL four%0d_out: got %b %b %b want %b %b 0", t, skill4, heavy4, tele4, want_skill[t], want_heavy[t]);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq[5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        foreach (seq[k]) begin
            tick(2'b00, seq[k]);
            if (obs4 !== exp4()) begin errors++; $display("FAIL b2b cyc%0d: got %h want %h", k, obs4, exp4()); end
            checks++;
            if (k == 3 && (valid4 !== 1'b1 || skill4 !== 8'b11100100)) begin
                errors++; $display("FAIL b2b_valid: got %b %b want 1 11100100", valid4, skill4);
            end
            if (k == 3) checks++;
        end
        if (count4 !== 3'd1 || state4 !== 2'b01 || valid4 !== 1'b0) begin
            errors++; $display("FAIL b2b_next: got %0d %b %b want 1 01 0", count4, state4, valid4);
        end
        checks++;
        settle();
    endtask

    task automatic test_random();
        logic [1:0] b2 = 2'b00;
        logic [3:0] b4 = 4'd0;
        for (int c = 0; c < 800; c++) begin
            if ((c % 100) >= 80) begin
                b2 = 2'b00; b4 = 4'd0;
            end else begin
                if ($urandom_range(0, 2) == 0) b2 = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) b4 = 4'(1 << $urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 4'b0001 : 4'b0000);
            end
            tick(b2, b4);
            if ({obs2, obs4} !== {exp2(), exp4()}) begin
                errors++; $display("FAIL random cyc%0d: got %h/%h want %h/%h", c, obs2, obs4, exp2(), exp4());
            end
            checks++;
        end
    endtask

    initial begin
        mreset(0);
        mreset(1);
        repeat (2) @(posedge clk);
        test_reset();
        test_teleport();
        test_heavy();
        test_timeout();
        test_press_at_timeout();
        test_clash();
        test_cooldown();
        test_reset_mid();
        test_four();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
